sid_voice_mixer: RTL and testbench

Parametrised N-voice mixer. It sits between several SID voice generators and the delta-sigma DAC, and is the next step after the single-voice signal chain. Once per sample period it snapshots every unsigned voice word and every per-voice gain, then accumulates them one voice per clock. It then emits one saturated, offset-binary mix word for the DAC, with a valid strobe and a sticky clip flag.

---
 rtl/sid_voice_mixer.sv | 193 +++++++++++++++++++
 tb/tb_sid_voice_mixer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sid_voice_mixer.sv
// N-voice SID mixer: snapshots voices and gains once per sample period, accumulates
// one voice per clock, and emits a saturated offset-binary word with a sticky clip flag.
module sid_voice_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int VOICE_W    = 12,
    parameter int GAIN_W     = 4,
    parameter int SAMPLE_DIV = 16,
    localparam int ADDR_W    = $clog2(NUM_VOICES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_VOICES*VOICE_W-1:0] voice_in,
    input  logic                          cfg_we,
    input  logic [ADDR_W-1:0]             cfg_addr,
    input  logic [7:0]                    cfg_data,
    output logic [VOICE_W-1:0]            mix_out,
    output logic                          mix_valid,
    output logic                          clip,
    output logic                          busy
);

    localparam int ACC_W  = VOICE_W + GAIN_W + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W = VOICE_W + GAIN_W + 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [VOICE_W-1:0]      MID_WORD   = {1'b1, {(VOICE_W-1){1'b0}}};
    localparam logic [GAIN_W-1:0]       GAIN_UNITY = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'((32'sd1 <<< (VOICE_W-1)) - 32'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-(32'sd1 <<< (VOICE_W-1)));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Offset-binary to two's complement: flipping the MSB recentres silence at zero.
    function automatic logic signed [VOICE_W-1:0] to_signed_voice(input logic [VOICE_W-1:0] v);
        return {~v[VOICE_W-1], v[VOICE_W-2:0]};
    endfunction

    state_t                    state_r;
    logic [DIV_W-1:0]          div_r;
    logic [IDX_W-1:0]          idx_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic signed [VOICE_W-1:0] snap_v_r [NUM_VOICES];
    logic [GAIN_W-1:0]         snap_g_r [NUM_VOICES];
    logic [GAIN_W-1:0]         gain_r   [NUM_VOICES];
    logic [VOICE_W-1:0]        mix_out_r;
    logic                      mix_valid_r;
    logic                      clip_r;
    logic                      busy_r;

    logic                      tick_s;
    logic                      pre_tick_s;
    logic                      last_s;
    logic [PROD_W-1:0]         v_ext_s;
    logic [PROD_W-1:0]         g_ext_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   acc_next_s;
    logic signed [ACC_W-1:0]   shifted_s;
    logic [VOICE_W-1:0]        sat_s;
    logic                      sat_hit_s;
    logic [VOICE_W-1:0]        mix_word_s;
    logic                      clip_set_s;
    logic                      clip_clr_s;
    logic                      cfg_unused_s;

    assign tick_s       = (div_r == DIV_W'(SAMPLE_DIV - 1));
    assign pre_tick_s   = (div_r == DIV_W'(SAMPLE_DIV - 2));
    assign last_s       = (idx_r == IDX_W'(NUM_VOICES - 1));
    assign clip_set_s   = (state_r == ST_ACC) && last_s && sat_hit_s;
    assign clip_clr_s   = cfg_we && (cfg_addr == ADDR_W'(NUM_VOICES)) && cfg_data[0];
    assign cfg_unused_s = ^cfg_data;

    // The final accumulation is resolved in the last ACC cycle so the word is registered on entry to OUT.
    always_comb begin
        v_ext_s    = {{(GAIN_W+1){snap_v_r[idx_r][VOICE_W-1]}}, snap_v_r[idx_r]};
        g_ext_s    = {{VOICE_W{1'b0}}, 1'b0, snap_g_r[idx_r]};
        prod_s     = $signed(v_ext_s) * $signed(g_ext_s);
        acc_next_s = acc_r + ACC_W'(prod_s);
        shifted_s  = acc_next_s >>> (GAIN_W - 1);
        sat_s      = shifted_s[VOICE_W-1:0];
        sat_hit_s  = 1'b0;
        if (shifted_s > SAT_MAX) begin
            sat_s     = SAT_MAX[VOICE_W-1:0];
            sat_hit_s = 1'b1;
        end else if (shifted_s < SAT_MIN) begin
            sat_s     = SAT_MIN[VOICE_W-1:0];
            sat_hit_s = 1'b1;
        end else begin
            sat_s     = shifted_s[VOICE_W-1:0];
            sat_hit_s = 1'b0;
        end
        mix_word_s = {~sat_s[VOICE_W-1], sat_s[VOICE_W-2:0]};
    end

    // Free-running sample-rate divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Per-voice gain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) gain_r[i] <= GAIN_UNITY;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (cfg_we && (cfg_addr == ADDR_W'(i))) gain_r[i] <= cfg_data[GAIN_W-1:0];
                else                                     gain_r[i] <= gain_r[i];
            end
        end
    end

    // Mix sequencer; busy is raised one cycle early so it is already high in the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            mix_out_r   <= MID_WORD;
            mix_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                snap_v_r[i] <= {VOICE_W{1'b0}};
                snap_g_r[i] <= {GAIN_W{1'b0}};
            end
        end else begin
            mix_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        state_r <= ST_ACC;
                        idx_r   <= {IDX_W{1'b0}};
                        acc_r   <= {ACC_W{1'b0}};
                        busy_r  <= 1'b1;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            snap_v_r[i] <= to_signed_voice(voice_in[i*VOICE_W +: VOICE_W]);
                            snap_g_r[i] <= gain_r[i];
                        end
                    end else begin
                        busy_r <= pre_tick_s;
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_next_s;
                    if (last_s) begin
                        state_r     <= ST_OUT;
                        idx_r       <= {IDX_W{1'b0}};
                        mix_out_r   <= mix_word_s;
                        mix_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_OUT: begin
                    state_r <= ST_IDLE;
                    busy_r  <= pre_tick_s;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky clip flag; a saturation in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_r <= 1'b0;
        end else if (clip_set_s) begin
            clip_r <= 1'b1;
        end else if (clip_clr_s) begin
            clip_r <= 1'b0;
        end else begin
            clip_r <= clip_r;
        end
    end

    assign mix_out   = mix_out_r;
    assign mix_valid = mix_valid_r;
    assign clip      = clip_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sid_voice_mixer.sv
// Scoreboard bench for sid_voice_mixer: an arithmetic reference model queues expected
// mix words at each sample tick and an independent monitor checks them as they appear.
module tb_sid_voice_mixer;

    localparam int NV = 3;
    localparam int VW = 12;
    localparam int GW = 4;
    localparam int SD = 16;
    localparam int AW = 2;
    localparam int UNITY = 8;
    localparam int HALF  = 2048;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NV*VW-1:0] voice_in;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [7:0]       cfg_data;
    logic [VW-1:0]    mix_out;
    logic             mix_valid;
    logic             clip;
    logic             busy;

    sid_voice_mixer #(.NUM_VOICES(NV), .VOICE_W(VW), .GAIN_W(GW), .SAMPLE_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .voice_in(voice_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .mix_out(mix_out), .mix_valid(mix_valid), .clip(clip), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int due; bit clamp; } exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   k_m = 0;
    int   gain_m[NV];
    bit   clip_exp = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, k_m);
        end
    endtask

    // Reference: signed sum of (voice - midpoint) * gain, floored division by unity, clamped.
    task automatic model_mix(input logic [NV*VW-1:0] v, output int val, output bit clamp);
        int sum = 0;
        int r;
        for (int i = 0; i < NV; i++) sum += (int'(v[i*VW +: VW]) - HALF) * gain_m[i];
        r = (sum >= 0) ? sum / UNITY : -((-sum + UNITY - 1) / UNITY);
        clamp = 1'b0;
        if (r > HALF - 1) begin r = HALF - 1; clamp = 1'b1; end
        if (r < -HALF)    begin r = -HALF;    clamp = 1'b1; end
        val = r + HALF;
    endtask

    // Model: tracks cycles since reset release, queues expected samples, mirrors gains and clip.
    initial begin
        int v;
        bit c;
        foreach (gain_m[i]) gain_m[i] = UNITY;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                k_m = 0;
                exp_q.delete();
                foreach (gain_m[i]) gain_m[i] = UNITY;
                clip_exp = 1'b0;
            end else begin
                if (k_m % SD == SD - 1) begin
                    model_mix(voice_in, v, c);
                    exp_q.push_back('{v, k_m + NV + 1, c});
                end
                if (cfg_we && int'(cfg_addr) < NV) gain_m[cfg_addr] = int'(cfg_data[GW-1:0]);
                if (cfg_we && int'(cfg_addr) == NV && cfg_data[0]) clip_exp = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].due == k_m + 1 && exp_q[0].clamp) clip_exp = 1'b1;
                k_m++;
            end
        end
    end

    // Monitor: compares every presented sample, its timing, busy and clip.
    initial begin
        exp_t e;
        bit   busy_exp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                busy_exp = (k_m >= SD - 1) && (((k_m - (SD - 1)) % SD) <= NV + 1);
                chk("busy", int'(busy), int'(busy_exp));
                chk("clip", int'(clip), int'(clip_exp));
                if (mix_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mix_out", int'(mix_out), e.val);
                        chk("valid_cycle", k_m, e.due);
                    end
                end else if (exp_q.size() > 0 && k_m >= exp_q[0].due) begin
                    e = exp_q.pop_front();
                    chk("missing_valid", k_m, e.due);
                end
            end
        end
    end

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = 8'(data);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic set_voice(input int i, input logic [VW-1:0] v);
        voice_in[i*VW +: VW] = v;
    endtask

    task automatic wait_valid(input string name, input int req, output int at_k);
        bit found = 1'b0;
        at_k = -1;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (mix_valid) begin
                found = 1'b1;
                at_k  = k_m;
                chk(name, int'(mix_out), req);
            end
        end
        if (!found) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_phase(input int ph);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (k_m % SD == ph && k_m > SD) break;
        end
    endtask

    initial begin
        int k;
        voice_in = {NV{12'h800}};
        cfg_we   = 1'b0;
        cfg_addr = {AW{1'b0}};
        cfg_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_mix_out", int'(mix_out), 'h800);
        chk("reset_clip", int'(clip), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(mix_valid), 0);

        // Silence and sample cadence
        wait_valid("silence1", 'h800, k);
        chk("first_valid_cycle", k, 19);
        wait_valid("silence2", 'h800, k);
        chk("second_valid_cycle", k, 35);

        // Single voice at unity gain, then gain scaling
        set_voice(0, 12'hA00);
        wait_valid("unity_voice0", 'hA00, k);
        cfg_write(0, 4);
        wait_valid("gain4", 'h900, k);
        cfg_write(0, 0);
        wait_valid("gain0", 'h800, k);
        cfg_write(0, 15);
        set_voice(0, 12'h7FF);
        wait_valid("gain15_neg", 'h7FE, k);

        // Saturation and sticky clip
        cfg_write(0, UNITY);
        voice_in = {NV{12'hFFF}};
        wait_valid("sat_high", 'hFFF, k);
        chk("clip_set", int'(clip), 1);
        voice_in = {NV{12'h000}};
        wait_valid("sat_low", 'h000, k);
        chk("clip_sticky", int'(clip), 1);
        voice_in = {NV{12'h800}};
        cfg_write(NV, 8'hFE);
        cfg_write(NV, 8'h01);
        wait_valid("after_clear", 'h800, k);
        chk("clip_cleared", int'(clip), 0);

        // Snapshot coherence: inputs change two cycles into the mix
        set_voice(0, 12'hA00);
        wait_phase(1);
        set_voice(0, 12'h900);
        set_voice(1, 12'h900);
        cfg_write(0, 0);
        wait_valid("snapshot_held", 'hA00, k);
        wait_valid("snapshot_next", 'h900, k);

        // Reset in the middle of accumulation
        cfg_write(0, 4);
        cfg_write(1, 2);
        set_voice(0, 12'hA00);
        wait_phase(1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mix_out", int'(mix_out), 'h800);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(mix_valid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("gains_unity_after_reset", 'hB00, k);
        chk("post_reset_cycle", k, 19);

        // Randomised voices, gain writes and clip clears
        for (int s = 0; s < 40; s++) begin
            repeat ($urandom_range(2, 12)) @(negedge clk);
            for (int i = 0; i < NV; i++) voice_in[i*VW +: VW] = VW'($urandom);
            if ($urandom_range(0, 2) != 0) cfg_write(int'($urandom_range(0, NV)), int'($urandom_range(0, 255)));
        end
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
